// File: rtl/enemy_spawner_if.sv
// Spawn-offer handshake between the enemy spawner (master) and the enemy-object manager (slave).
interface enemy_spawner_if;
  logic       spawn_valid;
  logic [3:0] spawn_col;
  logic [1:0] spawn_type;
  logic       spawn_ack;

  modport master (
    output spawn_valid,
    output spawn_col,
    output spawn_type,
    input  spawn_ack
  );

  modport slave (
    input  spawn_valid,
    input  spawn_col,
    input  spawn_type,
    output spawn_ack
  );
endinterface

// File: rtl/enemy_spawner.sv
// Schedules enemy spawns from a free-running random value, offers them over a valid/ack
// handshake and keeps a saturating count of live enemies capped at MAX_ENEMIES.
module enemy_spawner #(
  parameter int MIN_GAP     = 4,
  parameter int MAX_ENEMIES = 8,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       rnd,
  input  logic             tick,
  input  logic             enable,
  input  logic             enemy_killed,
  enemy_spawner_if.master  spawn,
  output logic [CNT_W-1:0] alive_cnt
);

  localparam int GAP_W = $clog2(MIN_GAP + 4);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PICK,
    OFFER
  } state_t;

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_seed;
  logic [3:0]       last_col;
  logic [3:0]       col_q, col_pick;
  logic [1:0]       type_q, type_pick;
  logic             full;
  logic             valid;
  logic             accept;
  logic             gap_load;
  logic             gap_dec;
  logic             pick_load;

  assign full     = (alive_cnt == CNT_W'(MAX_ENEMIES));
  assign gap_seed = GAP_W'(MIN_GAP) + GAP_W'(rnd[1:0]);

  // Column de-duplication: a repeat of the previous column is nudged right, wrapping 15 -> 0.
  always_comb begin
    col_pick = rnd;
    if (rnd == last_col) col_pick = rnd + 4'd1;
  end

  always_comb begin
    type_pick = 2'd0;
    case (rnd[3:2])
      2'b10:   type_pick = 2'd1;
      2'b11:   type_pick = 2'd2;
      default: type_pick = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = WAIT;
        WAIT:    if (tick && (gap_cnt <= GAP_W'(1))) state_nxt = PICK;
        PICK:    state_nxt = full ? WAIT : OFFER;
        OFFER:   if (spawn.spawn_ack) state_nxt = WAIT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    valid     = (state == OFFER);
    accept    = valid && spawn.spawn_ack;
    gap_load  = ((state == IDLE) && enable) || ((state == PICK) && full) || accept;
    gap_dec   = (state == WAIT) && tick && (gap_cnt != '0);
    pick_load = (state == PICK) && enable && !full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt  <= '0;
      col_q    <= '0;
      type_q   <= '0;
      last_col <= '1;
    end else begin
      if (gap_load)     gap_cnt <= gap_seed;
      else if (gap_dec) gap_cnt <= gap_cnt - GAP_W'(1);
      if (pick_load) begin
        col_q  <= col_pick;
        type_q <= type_pick;
      end
      if (accept) last_col <= col_q;
    end
  end

  // Accept and kill in the same cycle cancel; kill saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_cnt <= '0;
    end else begin
      case ({accept, enemy_killed})
        2'b10:   if (!full) alive_cnt <= alive_cnt + CNT_W'(1);
        2'b01:   if (alive_cnt != '0) alive_cnt <= alive_cnt - CNT_W'(1);
        default: alive_cnt <= alive_cnt;
      endcase
    end
  end

  assign spawn.spawn_valid = valid;
  assign spawn.spawn_col   = col_q;
  assign spawn.spawn_type  = type_q;

endmodule

// File: tb/tb_enemy_spawner.sv
// Directed, table-driven bench for enemy_spawner with hand-computed expectations.
module tb_enemy_spawner;
  localparam int MIN_GAP     = 4;
  localparam int MAX_ENEMIES = 8;
  localparam int CNT_W       = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       rnd = 4'd0;
  logic             tick = 1'b0;
  logic             enable = 1'b0;
  logic             enemy_killed = 1'b0;
  logic [CNT_W-1:0] alive_cnt;

  enemy_spawner_if sif ();

  enemy_spawner #(
    .MIN_GAP     (MIN_GAP),
    .MAX_ENEMIES (MAX_ENEMIES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rnd          (rnd),
    .tick         (tick),
    .enable       (enable),
    .enemy_killed (enemy_killed),
    .spawn        (sif.master),
    .alive_cnt    (alive_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         ngap;
    logic [3:0] pick_rnd;
    int         exp_col;
    int         exp_type;
    logic [3:0] ack_rnd;
    int         exp_alive;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // n ticks spaced 3 clks apart; rnd held at pick_rnd so PICK samples it.
  task automatic run_gap(input int n, input logic [3:0] pick_rnd, input bit exp_offer,
                         input string tag);
    rnd = pick_rnd;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) chk({tag, " early"}, sif.spawn_valid, 0);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      if (i == n - 1) begin
        chk({tag, " pick"}, sif.spawn_valid, 0);
        cyc();
        chk({tag, " offer"}, sif.spawn_valid, exp_offer ? 1 : 0);
        cyc();
        chk({tag, " offer_hold"}, sif.spawn_valid, exp_offer ? 1 : 0);
      end else begin
        cyc();
        cyc();
      end
    end
  endtask

  task automatic ack_one(input logic [3:0] ack_rnd, input int exp_alive, input string tag);
    rnd = ack_rnd;
    sif.spawn_ack = 1'b1;
    cyc();
    sif.spawn_ack = 1'b0;
    chk({tag, " valid_drop"}, sif.spawn_valid, 0);
    chk({tag, " alive"}, alive_cnt, exp_alive);
  endtask

  initial begin
    sif.spawn_ack = 1'b0;
    // {ngap, pick_rnd, exp_col, exp_type, ack_rnd, exp_alive}
    vecs[0] = '{4, 4'b1010, 11, 1, 4'b0011, 2};  // collision with last_col 10
    vecs[1] = '{7, 4'b1111, 15, 2, 4'b0001, 3};
    vecs[2] = '{5, 4'b1111,  0, 2, 4'b0010, 4};  // collision wraps 15 -> 0
    vecs[3] = '{6, 4'b0000,  1, 0, 4'b0000, 5};
    vecs[4] = '{4, 4'b0100,  4, 0, 4'b0001, 6};
    vecs[5] = '{5, 4'b1101, 13, 2, 4'b0000, 7};
    vecs[6] = '{4, 4'b0000,  0, 0, 4'b0000, 8};

    cyc();
    cyc();
    chk("rst valid", sif.spawn_valid, 0);
    chk("rst col", sif.spawn_col, 0);
    chk("rst type", sif.spawn_type, 0);
    chk("rst alive", alive_cnt, 0);
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("idle valid", sif.spawn_valid, 0);

    enable = 1'b1;
    rnd    = 4'b0110;
    cyc();
    run_gap(6, 4'b1010, 1'b1, "t1");
    chk("t1 col", sif.spawn_col, 10);
    chk("t1 type", sif.spawn_type, 1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("hold valid", sif.spawn_valid, 1);
      chk("hold col", sif.spawn_col, 10);
      chk("hold type", sif.spawn_type, 1);
    end
    chk("hold alive", alive_cnt, 0);
    ack_one(4'b0000, 1, "t1 ack");

    for (int i = 0; i < 7; i++) begin
      run_gap(vecs[i].ngap, vecs[i].pick_rnd, 1'b1, $sformatf("v%0d", i));
      chk($sformatf("v%0d col", i), sif.spawn_col, vecs[i].exp_col);
      chk($sformatf("v%0d type", i), sif.spawn_type, vecs[i].exp_type);
      ack_one(vecs[i].ack_rnd, vecs[i].exp_alive, $sformatf("v%0d ack", i));
    end

    // Full: PICK skips and reloads gap = 4 + 2 from rnd sampled in PICK.
    run_gap(4, 4'b0010, 1'b0, "full");
    chk("full alive", alive_cnt, 8);
    enemy_killed = 1'b1;
    cyc();
    enemy_killed = 1'b0;
    chk("kill from full", alive_cnt, 7);
    run_gap(6, 4'b0111, 1'b1, "refill");
    chk("refill col", sif.spawn_col, 7);
    chk("refill type", sif.spawn_type, 0);

    for (int i = 0; i < 2; i++) begin
      enemy_killed = 1'b1;
      cyc();
      enemy_killed = 1'b0;
      chk("kill in offer", alive_cnt, 6 - i);
      chk("kill in offer valid", sif.spawn_valid, 1);
    end
    rnd           = 4'b0000;
    sif.spawn_ack = 1'b1;
    enemy_killed  = 1'b1;
    cyc();
    sif.spawn_ack = 1'b0;
    enemy_killed  = 1'b0;
    chk("ack+kill alive", alive_cnt, 5);
    chk("ack+kill valid", sif.spawn_valid, 0);

    sif.spawn_ack = 1'b1;
    cyc();
    sif.spawn_ack = 1'b0;
    chk("stray ack", alive_cnt, 5);

    for (int i = 0; i < 6; i++) begin
      enemy_killed = 1'b1;
      cyc();
      enemy_killed = 1'b0;
      chk("drain", alive_cnt, (i < 5) ? 4 - i : 0);
    end

    run_gap(4, 4'b0011, 1'b1, "drop");
    chk("drop col", sif.spawn_col, 3);
    enable = 1'b0;
    cyc();
    chk("drop valid", sif.spawn_valid, 0);
    chk("drop alive", alive_cnt, 0);
    cyc();
    enable = 1'b1;
    rnd    = 4'b0001;
    cyc();
    run_gap(5, 4'b0011, 1'b1, "reen");
    chk("reen col", sif.spawn_col, 3);
    chk("reen type", sif.spawn_type, 0);

    enable        = 1'b0;
    sif.spawn_ack = 1'b1;
    cyc();
    sif.spawn_ack = 1'b0;
    chk("ack on disable valid", sif.spawn_valid, 0);
    chk("ack on disable alive", alive_cnt, 1);

    enable = 1'b1;
    rnd    = 4'b0000;
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("pre-rst col", sif.spawn_col, 3);
    rst_n = 1'b0;
    #1;
    chk("async rst valid", sif.spawn_valid, 0);
    chk("async rst col", sif.spawn_col, 0);
    chk("async rst type", sif.spawn_type, 0);
    chk("async rst alive", alive_cnt, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
